mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates NUM_REQ requesters onto a single memory port, one transaction in flight at a time.
// Define MEM_ARB_FIXED_PRIO_EN to replace round-robin with lowest-index-wins priority.
module mem_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0]                 req_we,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic [NUM_REQ-1:0]                 resp_valid,
  output logic [NUM_REQ-1:0][DATA_WIDTH-1:0] resp_rdata,
  output logic                               mem_valid,
  output logic                               mem_we,
  output logic [ADDR_WIDTH-1:0]              mem_addr,
  output logic [DATA_WIDTH-1:0]              mem_wdata,
  input  logic                               mem_ready,
  input  logic                               mem_rvalid,
  input  logic [DATA_WIDTH-1:0]              mem_rdata,
  output logic                               busy
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitResp, StRespond} state_e;

  state_e                            state_q, state_d;
  logic [IdxW-1:0]                   grant_q, grant_d;
  logic [IdxW-1:0]                   winner;
  logic                              any_valid;
  logic                              we_q, we_d;
  logic [ADDR_WIDTH-1:0]             addr_q, addr_d;
  logic [DATA_WIDTH-1:0]             wdata_q, wdata_d;
  logic                              mem_valid_q, mem_valid_d;
  logic                              busy_q, busy_d;
  logic [NUM_REQ-1:0]                resp_valid_q, resp_valid_d;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

  assign any_valid = |req_valid;

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest valid index is written last and wins.
  always_comb begin
    winner = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req_valid[i]) winner = IdxW'(i);
    end
  end
`else
  logic [IdxW-1:0] last_q, last_d;
  int unsigned     rr_idx;

  // Scan offsets from farthest to nearest so the first requester after last_q wins.
  always_comb begin
    winner = '0;
    rr_idx = 0;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      rr_idx = (32'(last_q) + k) % NUM_REQ;
      if (req_valid[rr_idx]) winner = IdxW'(rr_idx);
    end
  end

  always_comb begin
    last_d = last_q;
    if (state_q == StIdle && any_valid) last_d = winner;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= IdxW'(NUM_REQ - 1);
    else     last_q <= last_d;
  end
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mem_valid_d  = 1'b0;
    resp_valid_d = '0;
    resp_rdata_d = '0;
    req_ready    = '0;

    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          req_ready[winner] = 1'b1;
          grant_d           = winner;
          we_d              = req_we[winner];
          addr_d            = req_addr[winner];
          wdata_d           = req_wdata[winner];
          mem_valid_d       = 1'b1;
          state_d           = StIssue;
        end
      end
      StIssue: begin
        mem_valid_d = 1'b1;
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          if (we_q) begin
            resp_valid_d[grant_q] = 1'b1;
            state_d               = StRespond;
          end else begin
            state_d = StWaitResp;
          end
        end
      end
      StWaitResp: begin
        if (mem_rvalid) begin
          resp_valid_d[grant_q] = 1'b1;
          resp_rdata_d[grant_q] = mem_rdata;
          state_d               = StRespond;
        end
      end
      StRespond: state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    // The accept strobe is the only combinational output; keep it quiet during reset.
    if (rst) req_ready = '0;
  end

  assign busy_d = (state_d != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mem_valid_q  <= mem_valid_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign mem_valid  = mem_valid_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed checks of mem_arbiter against a transaction-level reference model.
// Build with +define+MEM_ARB_FIXED_PRIO_EN to exercise the fixed-priority variant.
module tb_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  logic                   clk;
  logic                   rst;
  logic [N-1:0]           req_valid;
  logic [N-1:0]           req_we;
  logic [N-1:0][AW-1:0]   req_addr;
  logic [N-1:0][DW-1:0]   req_wdata;
  logic [N-1:0]           req_ready;
  logic [N-1:0]           resp_valid;
  logic [N-1:0][DW-1:0]   resp_rdata;
  logic                   mem_valid;
  logic                   mem_we;
  logic [AW-1:0]          mem_addr;
  logic [DW-1:0]          mem_wdata;
  logic                   mem_ready;
  logic                   mem_rvalid;
  logic [DW-1:0]          mem_rdata;
  logic                   busy;

  mem_arbiter #(
    .NUM_REQ    (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .mem_valid  (mem_valid),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one transaction record plus the arbitration pointer.
  bit          m_active, m_issued, m_respond, m_we;
  int          m_owner;
  int          m_last = N - 1;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_data;
  logic [N-1:0]  ready_seen;

  function automatic int pick(input logic [N-1:0] v, input int last);
`ifdef MEM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
`endif
    return -1;
  endfunction

  // Called at a negedge with inputs already driven; checks this cycle, then advances one clock.
  task automatic step();
    logic [N-1:0]         exp_ready, exp_rv;
    logic [N-1:0][DW-1:0] exp_rd;
    int g;
    #1;
    g         = pick(req_valid, m_last);
    exp_ready = '0;
    if (!rst && !m_active && g >= 0) exp_ready[g] = 1'b1;
    ready_seen = req_ready;
    check_eq("req_ready", req_ready, exp_ready);
    check_eq("busy", busy, m_active);
    check_eq("mem_valid", mem_valid, m_active && !m_issued);
    if (m_active && !m_issued) begin
      check_eq("mem_we", mem_we, m_we);
      check_eq("mem_addr", mem_addr, m_addr);
      check_eq("mem_wdata", mem_wdata, m_wdata);
    end
    exp_rv = '0;
    exp_rd = '0;
    if (m_respond) begin
      exp_rv[m_owner] = 1'b1;
      if (!m_we) exp_rd[m_owner] = m_data;
    end
    check_eq("resp_valid", resp_valid, exp_rv);
    check_eq("resp_rdata", resp_rdata, exp_rd);
    check_eq("onehot_ready", $onehot0(req_ready), 1'b1);
    check_eq("onehot_resp", $onehot0(resp_valid), 1'b1);

    if (rst) begin
      m_active = 0; m_issued = 0; m_respond = 0; m_last = N - 1;
    end else if (!m_active) begin
      if (g >= 0) begin
        m_active = 1; m_issued = 0; m_respond = 0; m_owner = g; m_last = g;
        m_we = req_we[g]; m_addr = req_addr[g]; m_wdata = req_wdata[g];
      end
    end else if (m_respond) begin
      m_active = 0; m_respond = 0;
    end else if (!m_issued) begin
      if (mem_ready) begin
        m_issued = 1;
        if (m_we) m_respond = 1;
      end
    end else if (mem_rvalid) begin
      m_data = mem_rdata; m_respond = 1;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    step();
    rst = 1'b0;
    check_eq("rst_mem_we", mem_we, 1'b0);
    check_eq("rst_mem_addr", mem_addr, 8'h00);
    check_eq("rst_mem_wdata", mem_wdata, 8'h00);
    step();

    // Single read from requester 0: resp_valid three cycles after acceptance.
    req_valid = 4'b0001; req_addr[0] = 8'h10; mem_ready = 1'b1;
    step();
    check_eq("rd_mem_valid_c1", mem_valid, 1'b1);
    check_eq("rd_mem_addr_c1", mem_addr, 8'h10);
    req_valid = '0;
    step();
    check_eq("rd_mem_valid_c2", mem_valid, 1'b0);
    mem_rvalid = 1'b1; mem_rdata = 8'hA5;
    step();
    check_eq("rd_resp_valid_c3", resp_valid, 4'b0001);
    check_eq("rd_resp_rdata_c3", resp_rdata[0], 8'hA5);
    mem_rvalid = 1'b0;
    step();
    check_eq("rd_busy_c4", busy, 1'b0);

    // Write from requester 2 stalled by mem_ready; request lines change after acceptance.
    req_valid = 4'b0100; req_we = 4'b0100; req_addr[2] = 8'h22; req_wdata[2] = 8'h5A;
    mem_ready = 1'b0;
    step();
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      check_eq("wr_mem_valid", mem_valid, 1'b1);
      check_eq("wr_mem_we", mem_we, 1'b1);
      check_eq("wr_mem_addr", mem_addr, 8'h22);
      check_eq("wr_mem_wdata", mem_wdata, 8'h5A);
      req_addr[2] = 8'hFF; req_wdata[2] = 8'h00;
      mem_ready = (k == 3);
      step();
    end
    check_eq("wr_resp_valid", resp_valid, 4'b0100);
    check_eq("wr_resp_rdata", resp_rdata, 32'h0);
    mem_ready = 1'b0;
    step();
    idle_inputs();

    // Reset while waiting for read data, then a late rvalid pulse.
    req_valid = 4'b0001; mem_ready = 1'b1;
    step();
    req_valid = '0;
    step();
    check_eq("rw_busy_wait", busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rw_busy", busy, 1'b0);
    check_eq("rw_mem_valid", mem_valid, 1'b0);
    check_eq("rw_mem_addr", mem_addr, 8'h00);
    check_eq("rw_resp_valid", resp_valid, 4'b0000);
    mem_rvalid = 1'b1; mem_rdata = 8'h3C;
    step();
    check_eq("rw_no_resp", resp_valid, 4'b0000);
    mem_rvalid = 1'b0;
    req_valid = 4'b1000; req_addr[3] = 8'h33;
    step();
    check_eq("rw_grant3", ready_seen, 4'b1000);
    req_valid = '0; mem_rvalid = 1'b1; mem_rdata = 8'h77;
    for (int k = 0; k < 4; k++) step();
    idle_inputs();

`ifndef MEM_ARB_FIXED_PRIO_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = 4'b1111; req_we = 4'b1111; mem_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      ready_seen = '0;
      for (int k = 0; k < 10; k++) begin
        step();
        if (ready_seen != '0) break;
      end
      check_eq("rr_grant", ready_seen, 4'b0001 << order[t]);
    end
`else
    req_valid = 4'b1010; req_we = 4'b1010; mem_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      ready_seen = '0;
      for (int k = 0; k < 10; k++) begin
        step();
        if (ready_seen != '0) break;
      end
      check_eq("fp_grant", ready_seen, 4'b0010);
    end
`endif
    idle_inputs();

    for (int c = 0; c < 1500; c++) begin
      rst        = ($urandom_range(0, 149) == 0);
      req_valid  = N'($urandom);
      req_we     = N'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      mem_ready  = $urandom_range(0, 1) == 1;
      mem_rvalid = $urandom_range(0, 2) == 0;
      mem_rdata  = DW'($urandom);
      step();
    end

    rst = 1'b1;
    idle_inputs();
    step();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

endmodule
